// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the default memory geometry used by the data memory instance.
package dmem_arbiter_pkg;

    // Arbiter ownership state: normal priority arbitration or loader exclusive.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Default data memory geometry (64 x 32).
    localparam int DMEM_ADDR_W = 6;
    localparam int DMEM_DATA_W = 32;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one single-port memory between the pipeline
// MEM stage (priority, same-cycle access) and the loader/debug port.
// A starvation counter bounds how long the loader can be denied, and a lock
// mode hands the loader exclusive ownership for bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // pipeline MEM stage
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    // loader / debug port
    input  logic              l_req,
    input  logic              l_lock,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_rvalid,
    // data memory
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    arb_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [DATA_W-1:0] l_rdata_reg;
    logic              l_rvalid_reg;

    // Raw grants drive next-state logic; the outputs below are additionally
    // qualified by rst_n so nothing reaches memory while reset is held.
    logic              l_grant_raw;
    logic              p_grant_raw;
    logic              l_grant;
    logic              p_grant;

    // State register and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ARB;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Grant decision, next state and next starvation count.
    always_comb begin
        l_grant_raw   = 1'b0;
        p_grant_raw   = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ARB: begin
                // Pipeline wins unless idle or the loader has waited long enough.
                if (l_req && (!p_req || wait_cnt_reg == WAIT_LIMIT)) begin
                    l_grant_raw = 1'b1;
                end else if (p_req) begin
                    p_grant_raw = 1'b1;
                end
                if (l_grant_raw && l_lock) begin
                    state_next = LOCK;
                end
                if (l_grant_raw || !l_req) begin
                    wait_cnt_next = '0;
                end else if (p_grant_raw && wait_cnt_reg != WAIT_LIMIT) begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            LOCK: begin
                // Loader owns the memory; the counter is frozen while locked.
                l_grant_raw = l_req;
                if (!l_req || !l_lock) begin
                    state_next = ARB;
                end
            end
            default: begin
                state_next    = ARB;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Qualified grants, stall and memory port mux.
    always_comb begin
        l_grant  = l_grant_raw && rst_n;
        p_grant  = p_grant_raw && rst_n;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_in   = '0;
        if (l_grant) begin
            mem_we   = l_we;
            mem_addr = l_addr;
            mem_in   = l_wdata;
        end else if (p_grant) begin
            mem_we   = p_we;
            mem_addr = p_addr;
            mem_in   = p_wdata;
        end
    end

    // Loader read return: capture memory data one cycle after a granted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_rdata_reg  <= '0;
            l_rvalid_reg <= 1'b0;
        end else begin
            l_rvalid_reg <= l_grant_raw && !l_we;
            if (l_grant_raw && !l_we) begin
                l_rdata_reg <= mem_out;
            end
        end
    end

    assign p_stall  = p_req && !p_grant;
    assign p_rdata  = mem_out;
    assign l_gnt    = l_grant;
    assign l_rdata  = l_rdata_reg;
    assign l_rvalid = l_rvalid_reg;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, hand-written corner
// sequences (loader read, lock burst, reset mid-lock) and a randomized phase
// checked against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p_req, p_we, l_req, l_lock, l_we;
    logic [AW-1:0] p_addr, l_addr;
    logic [DW-1:0] p_wdata, l_wdata;
    logic [DW-1:0] p_rdata, l_rdata;
    logic          p_stall, l_gnt, l_rvalid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in, mem_out;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .l_req(l_req), .l_lock(l_lock), .l_we(l_we), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // Data memory: asynchronous read, synchronous write.
    logic [DW-1:0] tbmem [64];
    always @(posedge clk) if (mem_we) tbmem[mem_addr] <= mem_in;
    assign mem_out = tbmem[mem_addr];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic pr, input logic pw, input logic [AW-1:0] pa,
                          input logic [DW-1:0] pd, input logic lr, input logic ll,
                          input logic lw, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        @(negedge clk);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        l_req = lr; l_lock = ll; l_we = lw; l_addr = la; l_wdata = ld;
        #1;
        $display("[TB] t=%0t p(req=%0b we=%0b a=%0d) l(req=%0b lock=%0b we=%0b a=%0d) -> stall=%0b gnt=%0b mem_we=%0b mem_addr=%0d rvalid=%0b",
                 $time, pr, pw, pa, lr, ll, lw, la, p_stall, l_gnt, mem_we, mem_addr, l_rvalid);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic          p_req, p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        logic          l_req, l_lock, l_we;
        logic [AW-1:0] l_addr;
        logic [DW-1:0] l_wdata;
        logic          e_stall, e_gnt, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_in;
        logic          chk_rd;
        logic [DW-1:0] e_prdata;
        logic          e_rvalid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic pr, logic pw, logic [AW-1:0] pa, logic [DW-1:0] pd,
                                logic lr, logic ll, logic lw, logic [AW-1:0] la,
                                logic [DW-1:0] ld, logic es, logic eg, logic ew,
                                logic [AW-1:0] ea, logic [DW-1:0] ei, logic cr,
                                logic [DW-1:0] erd, logic erv);
        vec_t v;
        v.p_req = pr; v.p_we = pw; v.p_addr = pa; v.p_wdata = pd;
        v.l_req = lr; v.l_lock = ll; v.l_we = lw; v.l_addr = la; v.l_wdata = ld;
        v.e_stall = es; v.e_gnt = eg; v.e_we = ew; v.e_addr = ea; v.e_in = ei;
        v.chk_rd = cr; v.e_prdata = erd; v.e_rvalid = erv;
        return v;
    endfunction

    // Behavioural model state for the randomized phase.
    logic [DW-1:0] shadow [64];
    bit            m_locked;
    int            m_denied;
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int denied;
        bit got;
        for (int i = 0; i < 64; i++) tbmem[i] = '0;
        rst_n = 1'b0;
        p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        l_req = 0; l_lock = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        #1;
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("reset_l_rvalid", {31'd0, l_rvalid}, 32'd0);
        chk("reset_l_rdata", l_rdata, 32'd0);
        p_req = 1; #1;
        chk("reset_p_stall", {31'd0, p_stall}, 32'd1);
        p_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed vector table ----------------
        tbl.push_back(mk(0,0,0,0,           0,0,0,0,0,      0,0,0,0,0,          0,0,0));
        tbl.push_back(mk(1,1,5,32'hDEADBEEF,0,0,0,0,0,      0,0,1,5,32'hDEADBEEF,0,0,0));
        tbl.push_back(mk(1,0,5,0,           0,0,0,0,0,      0,0,0,5,0,          1,32'hDEADBEEF,0));
        tbl.push_back(mk(0,0,0,0,           0,0,0,0,0,      0,0,0,0,0,          0,0,0));
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                tbl.push_back(mk(1,0,1,0, 1,0,1,9,32'hA5, 0,0,0,1,0,         0,0,0));
            tbl.push_back(mk(1,0,1,0,     1,0,1,9,32'hA5, 1,1,1,9,32'hA5,    0,0,0));
        end
        tbl.push_back(mk(0,0,0,0,           0,0,0,0,0,      0,0,0,0,0,          0,0,0));
        tbl.push_back(mk(1,0,9,0,           0,0,0,0,0,      0,0,0,9,0,          1,32'hA5,0));

        foreach (tbl[i]) begin
            set_in(tbl[i].p_req, tbl[i].p_we, tbl[i].p_addr, tbl[i].p_wdata,
                   tbl[i].l_req, tbl[i].l_lock, tbl[i].l_we, tbl[i].l_addr, tbl[i].l_wdata);
            chk($sformatf("vec%0d_p_stall", i), {31'd0, p_stall}, {31'd0, tbl[i].e_stall});
            chk($sformatf("vec%0d_l_gnt", i), {31'd0, l_gnt}, {31'd0, tbl[i].e_gnt});
            chk($sformatf("vec%0d_mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].e_we});
            chk($sformatf("vec%0d_mem_addr", i), {26'd0, mem_addr}, {26'd0, tbl[i].e_addr});
            chk($sformatf("vec%0d_mem_in", i), mem_in, tbl[i].e_in);
            chk($sformatf("vec%0d_l_rvalid", i), {31'd0, l_rvalid}, {31'd0, tbl[i].e_rvalid});
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_p_rdata", i), p_rdata, tbl[i].e_prdata);
        end

        // ---------------- loader read, 1-cycle latency ----------------
        set_in(1, 1, 3, 32'h12345678, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0, 3, 0);
        chk("lrd_gnt", {31'd0, l_gnt}, 32'd1);
        chk("lrd_stall", {31'd0, p_stall}, 32'd0);
        idle();
        chk("lrd_rvalid_n1", {31'd0, l_rvalid}, 32'd1);
        chk("lrd_rdata_n1", l_rdata, 32'h12345678);
        idle();
        chk("lrd_rvalid_n2", {31'd0, l_rvalid}, 32'd0);
        chk("lrd_rdata_hold", l_rdata, 32'h12345678);

        // ---------------- lock burst against a busy pipeline ----------------
        denied = 0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            set_in(1, 0, 40, 0, 1, 1, 1, 0, 32'hC0DE0000);
            if (l_gnt) got = 1; else denied++;
        end
        chk("lock_entry_granted", {31'd0, got}, 32'd1);
        chk("lock_entry_denied", denied, MW);
        chk("lock_w0_stall", {31'd0, p_stall}, 32'd1);
        chk("lock_w0_mem_we", {31'd0, mem_we}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            set_in(1, 0, 40, 0, 1, (i != 7), 1, AW'(i), 32'hC0DE0000 + i);
            chk($sformatf("lock_w%0d_gnt", i), {31'd0, l_gnt}, 32'd1);
            chk($sformatf("lock_w%0d_stall", i), {31'd0, p_stall}, 32'd1);
            chk($sformatf("lock_w%0d_addr", i), {26'd0, mem_addr}, i);
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lock_exit_stall", {31'd0, p_stall}, 32'd0);
        chk("lock_exit_gnt", {31'd0, l_gnt}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, AW'(i), 0, 0, 0, 0, 0, 0);
            chk($sformatf("lock_rd%0d", i), p_rdata, 32'hC0DE0000 + i);
        end

        // ---------------- reset asserted mid-lock ----------------
        idle();
        set_in(0, 0, 0, 0, 1, 1, 1, 20, 32'h11111111);
        chk("rl_enter_gnt", {31'd0, l_gnt}, 32'd1);
        set_in(1, 0, 0, 0, 1, 1, 0, 20, 0);
        chk("rl_lockrd_gnt", {31'd0, l_gnt}, 32'd1);
        chk("rl_lockrd_stall", {31'd0, p_stall}, 32'd1);
        set_in(1, 0, 0, 0, 1, 1, 1, 20, 32'h22222222);
        chk("rl_pre_rvalid", {31'd0, l_rvalid}, 32'd1);
        chk("rl_pre_mem_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rl_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rl_rst_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("rl_rst_rvalid", {31'd0, l_rvalid}, 32'd0);
        chk("rl_rst_p_stall", {31'd0, p_stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 0, 20, 0, 1, 0, 1, 21, 32'h33333333);
        chk("rl_post_stall", {31'd0, p_stall}, 32'd0);
        chk("rl_post_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("rl_post_no_commit", p_rdata, 32'h11111111);

        // ---------------- randomized phase vs behavioural model ----------------
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) shadow[i] = tbmem[i];
        m_locked = 0; m_denied = 0; m_rvalid = 0; m_rdata = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit lg, pg, ewe;
            logic [AW-1:0] ea;
            logic [DW-1:0] ei;
            @(negedge clk);
            p_req   = ($urandom_range(0, 9) < 6);
            p_we    = $urandom_range(0, 1);
            p_addr  = AW'($urandom_range(0, 15));
            p_wdata = $urandom;
            l_req   = ($urandom_range(0, 9) < 6);
            l_lock  = ($urandom_range(0, 9) < 4);
            l_we    = $urandom_range(0, 1);
            l_addr  = AW'($urandom_range(0, 15));
            l_wdata = $urandom;
            #1;
            lg  = l_req && (m_locked || !p_req || m_denied == MW);
            pg  = !m_locked && p_req && !lg;
            ewe = lg ? l_we : (pg ? p_we : 1'b0);
            ea  = lg ? l_addr : (pg ? p_addr : '0);
            ei  = lg ? l_wdata : (pg ? p_wdata : '0);
            $display("[TB] rnd%0d p(req=%0b we=%0b a=%0d) l(req=%0b lock=%0b we=%0b a=%0d) gnt=%0b stall=%0b",
                     cyc, p_req, p_we, p_addr, l_req, l_lock, l_we, l_addr, l_gnt, p_stall);
            chk("rnd_l_gnt", {31'd0, l_gnt}, {31'd0, lg});
            chk("rnd_p_stall", {31'd0, p_stall}, {31'd0, p_req && !pg});
            chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, ewe});
            chk("rnd_mem_addr", {26'd0, mem_addr}, {26'd0, ea});
            chk("rnd_mem_in", mem_in, ei);
            chk("rnd_l_rvalid", {31'd0, l_rvalid}, {31'd0, m_rvalid});
            chk("rnd_l_rdata", l_rdata, m_rdata);
            if (pg && !p_we) chk("rnd_p_rdata", p_rdata, shadow[p_addr]);
            @(posedge clk);
            m_rvalid = lg && !l_we;
            if (m_rvalid) m_rdata = shadow[l_addr];
            if (lg && l_we) shadow[l_addr] = l_wdata;
            else if (pg && p_we) shadow[p_addr] = p_wdata;
            if (!m_locked) begin
                m_denied = (l_req && !lg) ? ((m_denied < MW) ? m_denied + 1 : MW) : 0;
                m_locked = lg && l_lock;
            end else begin
                m_locked = l_req && l_lock;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dmem_arbiter
